// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared widths, state encoding and helpers for the MEM->WB stage
//
// Purpose: default field widths, payload width helper, skid buffer occupancy
//          encoding and the control-bus bit map used by mem_wb_stage_hs.
// Ports:   none (package).
package mem_wb_pkg;

  localparam int DEF_CTRL_W = 3;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_W   = 5;
  localparam int DEF_PC_W   = 15;
  localparam int DEF_CNT_W  = 16;

  // Control bit 0 is the register-file write enable; the whole control bus is
  // zeroed on bubbles so this bit can never fire without a valid beat.
  localparam int CTRL_REGWRITE_BIT = 0;

  // The state value is the number of beats held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } skid_state_e;

  function automatic int payload_w(input int ctrl_w, input int data_w,
                                   input int rd_w, input int pc_w);
    return ctrl_w + 2 * data_w + rd_w + pc_w;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic 2-entry valid/ready skid buffer with flush
//
// Purpose: registers a W-bit payload between two valid/ready interfaces at full
//          throughput. in_ready depends only on the occupancy flop, so there is
//          no combinational path from out_ready back to in_ready.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous drop of all held beats
//   in_valid/in_ready   upstream handshake,  in_data  [W-1:0]
//   out_valid/out_ready downstream handshake, out_data [W-1:0] (main register)
module pipe_skid_buf
  import mem_wb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_xfer, out_xfer;

  // State and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next state and payload movement.
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    in_xfer  = in_valid & in_ready;
    out_xfer = out_valid & out_ready;
    if (flush) begin
      // Only occupancy is dropped; the payload registers keep stale data,
      // which is harmless because every consumer is qualified by out_valid.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_FULL;
            main_d  = in_data;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end else if (in_xfer) begin
            state_d = ST_SKID;
            skid_d  = in_data;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Outputs decoded from occupancy only.
  always_comb begin
    out_valid = (state_q == ST_FULL) || (state_q == ST_SKID);
    in_ready  = (state_q != ST_SKID);
    out_data  = main_q;
  end

endmodule

// File: rtl/mem_wb_stage_hs.sv
// rtl/mem_wb_stage_hs.sv - MEM->WB pipeline stage with valid/ready skid buffer
//
// Purpose: carries {control, mem_data, alu_output, rd, pc} from MEM to WB through
//          a 2-entry skid buffer, zeroes control on bubbles and counts stall
//          cycles (out_valid & !out_ready) in a saturating counter.
// Ports:
//   clk, rst_n, flush                       clock, async active-low reset, sync kill
//   in_valid/in_ready + *_in                MEM-side beat
//   out_valid/out_ready + *_out             WB-side beat (control_out gated)
//   stall_cnt, stall_clr                    saturating stall counter and its clear
module mem_wb_stage_hs
  import mem_wb_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W,
  parameter int PC_W   = DEF_PC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] alu_output_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic [PC_W-1:0]   pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] control_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] alu_output_out,
  output logic [RD_W-1:0]   rd_out,
  output logic [PC_W-1:0]   pc_out,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  localparam int PW = payload_w(CTRL_W, DATA_W, RD_W, PC_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PW-1:0]     in_payload, out_payload;
  logic [CTRL_W-1:0] main_control;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign in_payload = {control_in, mem_data_in, alu_output_in, rd_in, pc_in};

  pipe_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign {main_control, mem_data_out, alu_output_out, rd_out, pc_out} = out_payload;

  // A bubble must never write the register file.
  assign control_out = out_valid ? main_control : '0;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage_hs.sv
// tb/tb_mem_wb_stage_hs.sv - self-checking bench for mem_wb_stage_hs
module tb_mem_wb_stage_hs;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    logic [2:0]  c;
    logic [31:0] m;
    logic [31:0] a;
    logic [4:0]  r;
    logic [14:0] p;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_ready, out_valid, out_ready, stall_clr;
  logic [2:0]  control_in, control_out;
  logic [31:0] mem_data_in, alu_output_in, mem_data_out, alu_output_out;
  logic [4:0]  rd_in, rd_out;
  logic [14:0] pc_in, pc_out;
  logic [CNT_W-1:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  beat_t q[$];
  int    mcnt;

  always #5 clk = ~clk;

  mem_wb_stage_hs #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .control_in     (control_in),
    .mem_data_in    (mem_data_in),
    .alu_output_in  (alu_output_in),
    .rd_in          (rd_in),
    .pc_in          (pc_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .control_out    (control_out),
    .mem_data_out   (mem_data_out),
    .alu_output_out (alu_output_out),
    .rd_out         (rd_out),
    .pc_out         (pc_out),
    .stall_cnt      (stall_cnt),
    .stall_clr      (stall_clr)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input int k);
    beat_t b;
    b.c = 3'((k % 7) + 1);
    b.m = 32'hA000_0000 + 32'(k);
    b.a = 32'h5000_0000 ^ 32'(k * 3);
    b.r = 5'(k);
    b.p = 15'(k);
    return b;
  endfunction

  function automatic beat_t rnd();
    beat_t b;
    b.c = 3'($urandom);
    b.m = $urandom;
    b.a = $urandom;
    b.r = 5'($urandom);
    b.p = 15'($urandom);
    return b;
  endfunction

  task automatic put(input beat_t b);
    control_in    = b.c;
    mem_data_in   = b.m;
    alu_output_in = b.a;
    rd_in         = b.r;
    pc_in         = b.p;
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.c = control_in;
    b.m = mem_data_in;
    b.a = alu_output_in;
    b.r = rd_in;
    b.p = pc_in;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: an ordered queue of at most two held beats.
  always @(posedge clk or negedge rst_n) begin : model
    bit ov, ir;
    if (!rst_n) begin
      q.delete();
      mcnt = 0;
    end else begin
      ov = (q.size() > 0);
      ir = (q.size() < 2);
      if (stall_clr) mcnt = 0;
      else if (ov && !out_ready && mcnt < CMAX) mcnt++;
      if (flush) begin
        q.delete();
      end else begin
        if (ov && out_ready) void'(q.pop_front());
        if (in_valid && ir) q.push_back(cur_beat());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("m_out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("m_in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
        chk("m_control", 64'(control_out), 64'(q[0].c));
        chk("m_mem_data", 64'(mem_data_out), 64'(q[0].m));
        chk("m_alu", 64'(alu_output_out), 64'(q[0].a));
        chk("m_rd", 64'(rd_out), 64'(q[0].r));
        chk("m_pc", 64'(pc_out), 64'(q[0].p));
      end else begin
        chk("m_bubble_ctrl", 64'(control_out), 64'd0);
      end
      chk("m_stall_cnt", 64'(stall_cnt), 64'(mcnt));
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({nm, "_ctrl"}, 64'(control_out), 64'd0);
    chk({nm, "_data"}, {mem_data_out, alu_output_out}, 64'd0);
    chk({nm, "_rd_pc"}, 64'({rd_out, pc_out}), 64'd0);
    chk({nm, "_cnt"}, 64'(stall_cnt), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; stall_clr = 1'b0;
    put(mk(0));
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step();

    // 1: streaming, one-cycle latency, in order
    for (int i = 0; i < 8; i++) begin
      put(mk(i));
      in_valid = 1'b1;
      step();
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_pc", 64'(pc_out), 64'(i));
      chk("t1_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("t1_drained", 64'(out_valid), 64'd0);
    chk("t1_bubble_ctrl", 64'(control_out), 64'd0);

    // 2: back-pressure into skid, then drain A then B
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    out_ready = 1'b0;
    put(mk(20));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    put(mk(21));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t2_in_ready", 64'(in_ready), 64'd0);
    chk("t2_head", 64'(pc_out), 64'd20);
    chk("t2_cnt", 64'(stall_cnt), 64'd3);
    out_ready = 1'b1;
    step();
    chk("t2_b_pc", 64'(pc_out), 64'd21);
    chk("t2_b_valid", 64'(out_valid), 64'd1);
    step();
    chk("t2_empty", 64'(out_valid), 64'd0);
    chk("t2_cnt_hold", 64'(stall_cnt), 64'd3);

    // 3: flush from SKID drops both beats
    out_ready = 1'b0;
    put(mk(30)); in_valid = 1'b1; step();
    put(mk(31)); step();
    in_valid = 1'b0;
    chk("t3_skid", 64'(in_ready), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t3_valid", 64'(out_valid), 64'd0);
    chk("t3_ctrl", 64'(control_out), 64'd0);
    chk("t3_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    chk("t3_lost", 64'(out_valid), 64'd0);

    // 4: counter saturation and clear
    stall_clr = 1'b1; step(); stall_clr = 1'b0;
    out_ready = 1'b0;
    put(mk(40)); in_valid = 1'b1; step(); in_valid = 1'b0;
    repeat (20) step();
    chk("t4_sat", 64'(stall_cnt), 64'd15);
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    chk("t4_clr", 64'(stall_cnt), 64'd0);
    out_ready = 1'b1;
    step();

    // 5: asynchronous reset mid-stream
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(mk(50 + i));
      step();
    end
    out_ready = 1'b0;
    put(mk(53)); step();
    put(mk(54)); step();
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_zero("t5_async");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("t5_empty", 64'(out_valid), 64'd0);
    chk("t5_in_ready", 64'(in_ready), 64'd1);

    // 6: random traffic against the reference queue
    for (int i = 0; i < 10000; i++) begin
      put(rnd());
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      stall_clr = ($urandom_range(0, 127) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; stall_clr = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("t6_drained", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
